clut_load_ctrl: RTL and testbench



---
 rtl/clut_load_ctrl_if.sv | 24 ++
 rtl/clut_load_ctrl.sv | 80 ++++++++
 tb/tb_clut_load_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/clut_load_ctrl_if.sv
// clut_load_ctrl_if: request, VRAM burst-read and CLUT cache write-port signals of clut_load_ctrl.
interface clut_load_ctrl_if #(parameter int ADDR_W = 17);
  logic              i_loadReq;
  logic [14:0]       i_clutID;
  logic              i_is8bpp;
  logic              o_busy;
  logic              o_loadDone;
  logic              o_memReq;
  logic [ADDR_W-1:0] o_memAddr;
  logic              i_memAck;
  logic              i_memValid;
  logic [31:0]       i_memData;
  logic              o_write;
  logic [6:0]        o_writeIdx128;
  logic [31:0]       o_colorOut;
  modport master (
    input  i_loadReq, i_clutID, i_is8bpp, i_memAck, i_memValid, i_memData,
    output o_busy, o_loadDone, o_memReq, o_memAddr, o_write, o_writeIdx128, o_colorOut
  );
  modport slave (
    output i_loadReq, i_clutID, i_is8bpp, i_memAck, i_memValid, i_memData,
    input  o_busy, o_loadDone, o_memReq, o_memAddr, o_write, o_writeIdx128, o_colorOut
  );
endinterface

// File: rtl/clut_load_ctrl.sv
// clut_load_ctrl: fills the CLUT cache from VRAM in 8-word bursts (1 for 4bpp, 16 for 8bpp).
// Define CLUT_DEPTH_TAG_EN to skip refills of the most recently loaded CLUT.
module clut_load_ctrl (
  input  logic           clk,
  input  logic           i_nrst,
  clut_load_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;
  state_t      r_state, w_next;
  logic [14:0] r_id;
  logic        r_8bpp;
  logic [3:0]  r_burst;
  logic [2:0]  r_beat;
  logic        r_write, r_done;
  logic [6:0]  r_idx;
  logic [31:0] r_color;
  logic        w_accept, w_wr, w_end, w_last, w_hit, w_tag8;
  logic [7:0]  w_col;
`ifdef CLUT_DEPTH_TAG_EN
  logic [14:0] r_tag_id;
  logic        r_tag_8, r_tag_v;
  assign w_hit  = r_tag_v && r_tag_id == bus.i_clutID && (r_tag_8 || !bus.i_is8bpp);
  assign w_tag8 = w_hit && r_tag_8;
  always_ff @(posedge clk)
    if (!i_nrst) {r_tag_v, r_tag_8, r_tag_id} <= '0;
    else if (r_state == DONE) {r_tag_v, r_tag_8, r_tag_id} <= {1'b1, r_8bpp, r_id};
`else
  assign w_hit  = 1'b0;
  assign w_tag8 = 1'b0;
`endif
  // Column wraps inside the 256-word line; Y never sees a carry.
  assign w_col = 8'({r_id[5:0], 3'b000} + {5'd0, r_burst, 3'b000});
  assign w_accept = r_state == IDLE && bus.i_loadReq;
  assign w_wr     = r_state == DATA && bus.i_memValid;
  assign w_end    = w_wr && r_beat == 3'd7;
  assign w_last   = r_burst == (r_8bpp ? 4'd15 : 4'd0);
  assign bus.o_busy        = r_state != IDLE;
  assign bus.o_memReq      = r_state == REQ;
  assign bus.o_memAddr     = r_state == REQ ? {r_id[14:6], w_col} : '0;
  assign bus.o_write       = r_write;
  assign bus.o_writeIdx128 = r_idx;
  assign bus.o_colorOut    = r_color;
  assign bus.o_loadDone    = r_done;
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = w_hit ? DONE : REQ;
    if (r_state == REQ && bus.i_memAck) w_next = DATA;
    if (w_end) w_next = w_last ? DONE : REQ;
    if (r_state == DONE) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_8bpp  <= 1'b0;
      r_burst <= '0;
      r_beat  <= '0;
      r_write <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
      r_color <= '0;
    end else begin
      r_state <= w_next;
      r_write <= w_wr;
      r_done  <= r_state == DONE;
      if (w_accept) begin
        r_id    <= bus.i_clutID;
        r_8bpp  <= bus.i_is8bpp | w_tag8;
        r_burst <= '0;
        r_beat  <= '0;
      end
      if (w_wr) begin
        r_idx   <= {r_burst, r_beat};
        r_color <= bus.i_memData;
        r_beat  <= r_beat + 3'd1;
        if (r_beat == 3'd7) r_burst <= r_burst + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_clut_load_ctrl.sv
// tb_clut_load_ctrl: randomized fills against a queue scoreboard of expected addresses, writes and done pulses.
module tb_clut_load_ctrl;
`ifdef CLUT_DEPTH_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  typedef struct packed {logic [6:0] idx; logic [31:0] data;} wr_t;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;
  clut_load_ctrl_if bus();
  clut_load_ctrl dut (.clk(clk), .i_nrst(nrst), .bus(bus));
  wr_t         q_wr[$];
  logic [16:0] q_addr[$];
  int          done_exp = 0, done_cnt = 0, wr_cnt = 0;
  int          checks = 0, failures = 0;
  bit          tag_v = 1'b0, tag_8 = 1'b0;
  logic [14:0] tag_id = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=1 expected=0", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] exp_addr(input logic [14:0] id, input int b);
    int x, y;
    x = int'(id[5:0]);
    y = int'(id[14:6]);
    return 17'(y * 256 + (x * 8 + b * 8) % 256);
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    chk({tag, "_memreq"}, 32'(bus.o_memReq), 0);
    chk({tag, "_memaddr"}, 32'(bus.o_memAddr), 0);
    chk({tag, "_write"}, 32'(bus.o_write), 0);
    chk({tag, "_idx"}, 32'(bus.o_writeIdx128), 0);
    chk({tag, "_color"}, bus.o_colorOut, 0);
    chk({tag, "_loaddone"}, 32'(bus.o_loadDone), 0);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (nrst) begin
      if (bus.o_write) begin
        wr_cnt++;
        if (q_wr.size() == 0) flag("spurious_write");
        else begin
          e = q_wr.pop_front();
          chk("write_idx", 32'(bus.o_writeIdx128), 32'(e.idx));
          chk("write_data", bus.o_colorOut, e.data);
        end
      end
      if (bus.o_memReq) begin
        if (q_addr.size() == 0) flag("spurious_memreq");
        else begin
          chk("mem_addr", 32'(bus.o_memAddr), 32'(q_addr[0]));
          if (bus.i_memAck) void'(q_addr.pop_front());
        end
      end
      if (bus.o_loadDone) begin
        done_cnt++;
        if (done_exp == 0) flag("spurious_loaddone");
        else done_exp--;
        chk("busy_at_done", 32'(bus.o_busy), 0);
        chk("writes_retired", 32'(q_wr.size()), 0);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((bus.o_busy || bus.o_loadDone) && t < 100) begin
      step();
      t++;
    end
    if (t == 100) flag("idle_timeout");
  endtask

  task automatic do_abort();
    nrst = 1'b0;
    step();
    chk_outputs_zero("abort");
    q_wr.delete();
    q_addr.delete();
    tag_v = 1'b0;
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_memData = $urandom;
      step();
      chk("trail_no_write", 32'(bus.o_write), 0);
    end
    bus.i_memValid = 1'b0;
  endtask

  task automatic fill(input logic [14:0] id, input bit is8, input bit dir, input int ack_dly,
                      input int gap_beat, input int gap_len, input int abort_b, input bit repulse);
    bit hit;
    int nb, t, g;
    logic [31:0] d;
    wr_t e;
    hit = TAG_EN && tag_v && id == tag_id && (tag_8 || !is8);
    nb = hit ? 0 : (is8 ? 16 : 1);
    wait_idle();
    for (int b = 0; b < nb; b++) q_addr.push_back(exp_addr(id, b));
    if (abort_b < 0) done_exp++;
    bus.i_loadReq = 1'b1;
    bus.i_clutID = id;
    bus.i_is8bpp = is8;
    step();
    bus.i_loadReq = 1'b0;
    chk("busy_after_accept", 32'(bus.o_busy), 1);
    if (hit) begin
      chk("hit_no_memreq", 32'(bus.o_memReq), 0);
      step();
      chk("hit_done_latency", 32'(bus.o_loadDone), 1);
    end
    for (int b = 0; b < nb; b++) begin
      t = 0;
      while (!bus.o_memReq && t < 50) begin
        step();
        t++;
      end
      if (!bus.o_memReq) begin
        flag("memreq_timeout");
        break;
      end
      repeat (ack_dly >= 0 ? ack_dly : int'($urandom_range(0, 3))) step();
      bus.i_memAck = 1'b1;
      step();
      bus.i_memAck = 1'b0;
      for (int k = 0; k < 8; k++) begin
        g = gap_beat >= 0 ? (k == gap_beat ? gap_len : 0)
                          : int'($urandom_range(0, 2)) * int'($urandom_range(0, 1));
        repeat (g) step();
        d = dir ? ((32'((2 * k + 1) * 'h1111) << 16) | 32'((2 * k) * 'h1111)) : $urandom;
        bus.i_memValid = 1'b1;
        bus.i_memData = d;
        if (b == abort_b && k == 4) begin
          do_abort();
          return;
        end
        e.idx = 7'(b * 8 + k);
        e.data = d;
        q_wr.push_back(e);
        if (repulse && b == 0 && k == 2) bus.i_loadReq = 1'b1;
        step();
        bus.i_memValid = 1'b0;
        bus.i_loadReq = 1'b0;
      end
    end
    t = 0;
    while (!bus.o_loadDone && t < 20) begin
      step();
      t++;
    end
    chk("loaddone_seen", 32'(bus.o_loadDone), 1);
    step();
    chk("loaddone_one_cycle", 32'(bus.o_loadDone), 0);
    chk("busy_after_done", 32'(bus.o_busy), 0);
    if (!hit) begin
      tag_v = 1'b1;
      tag_id = id;
      tag_8 = is8;
    end
  endtask

  initial begin
    int w0, d0;
    logic [14:0] pool[4];
    pool[0] = 15'h1234;
    pool[1] = 15'h0042;
    pool[2] = 15'h7fff;
    pool[3] = 15'h0145;
    bus.i_loadReq = 1'b0;
    bus.i_clutID = '0;
    bus.i_is8bpp = 1'b0;
    bus.i_memAck = 1'b0;
    bus.i_memValid = 1'b0;
    bus.i_memData = '0;
    repeat (3) step();
    chk_outputs_zero("reset");
    nrst = 1'b1;
    step();
    fill(15'((5 << 6) | 2), 1'b0, 1'b1, 0, 8, 0, -1, 1'b0);
    w0 = wr_cnt;
    fill(15'd63, 1'b1, 1'b0, -1, -1, 0, -1, 1'b0);
    chk("writes_8bpp", 32'(wr_cnt - w0), 128);
    fill(15'h0a17, 1'b0, 1'b0, 5, 4, 3, -1, 1'b0);
    fill(15'h0abc, 1'b1, 1'b0, -1, -1, 0, 3, 1'b0);
    fill(15'h0abc, 1'b0, 1'b0, -1, -1, 0, -1, 1'b0);
    d0 = done_cnt;
    fill(15'h2e05, 1'b0, 1'b0, 1, -1, 0, -1, 1'b1);
    wait_idle();
    repeat (4) step();
    chk("repulse_one_done", 32'(done_cnt - d0), 1);
    fill(15'h1234, 1'b1, 1'b0, -1, -1, 0, -1, 1'b0);
    fill(15'h1234, 1'b1, 1'b0, -1, -1, 0, -1, 1'b0);
    fill(15'h1234, 1'b0, 1'b0, -1, -1, 0, -1, 1'b0);
    fill(15'h0042, 1'b0, 1'b0, -1, -1, 0, -1, 1'b0);
    w0 = wr_cnt;
    fill(15'h0042, 1'b1, 1'b0, -1, -1, 0, -1, 1'b0);
    chk("upgrade_full_fill", 32'(wr_cnt - w0), 128);
    for (int i = 0; i < 12; i++)
      fill(pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), 1'b0, -1, -1, 0, -1, 1'b0);
    wait_idle();
    repeat (4) step();
    chk("final_writes_pending", 32'(q_wr.size()), 0);
    chk("final_addr_pending", 32'(q_addr.size()), 0);
    chk("final_done_pending", 32'(done_exp), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
